sdr_data_path_cl: RTL and testbench

Parametrised SDRAM data-path block sitting between the 4-port SDRAM controller's command sequencer and the SDRAM DQ/DQM pins. Registers host write data, byte masks and the DQ output enable on write beats. Tracks issued read beats through a CAS-latency pipeline and returns captured read data with a valid strobe. Arbitrates DQ bus direction: write beats that would collide with returning read data are dropped and flagged.

---
 rtl/sdr_data_path_cl.sv | 90 +++++++++
 tb/tb_sdr_data_path_cl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sdr_data_path_cl.sv
// SDRAM DQ/DQM data path: registers write beats onto the pins, tracks issued
// reads through a CAS-latency pipeline and returns captured read data.
module sdr_data_path_cl #(
    parameter  int DSIZE       = 16,
    parameter  int CAS_LATENCY = 3,
    localparam int MSIZE       = DSIZE / 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             WR_EN,
    input  logic [DSIZE-1:0] DATAIN,
    input  logic [MSIZE-1:0] DM,
    input  logic             RD_CMD,
    input  logic [MSIZE-1:0] RD_DM,
    input  logic [DSIZE-1:0] DQIN,
    output logic [DSIZE-1:0] DQOUT,
    output logic             DQ_OE,
    output logic [MSIZE-1:0] DQM,
    output logic [DSIZE-1:0] DATAOUT,
    output logic             RD_VALID,
    output logic             RD_BUSY,
    output logic             WR_DROP
);

    generate
        if ((CAS_LATENCY != 2) && (CAS_LATENCY != 3)) begin : g_bad_cl
            $error("sdr_data_path_cl: CAS_LATENCY must be 2 or 3");
        end
        if ((DSIZE % 8) != 0 || DSIZE < 8 || DSIZE > 64) begin : g_bad_dsize
            $error("sdr_data_path_cl: DSIZE must be a multiple of 8 in 8..64");
        end
    endgenerate

    logic [CAS_LATENCY:0] r_rd_pipe;
    logic [DSIZE-1:0]     r_dqout;
    logic [DSIZE-1:0]     r_dataout;
    logic [MSIZE-1:0]     r_dqm;
    logic                 r_dq_oe;
    logic                 r_rd_valid;
    logic                 r_wr_drop;

    logic                 w_rd_cap;
    logic                 w_rd_due;
    logic                 w_wr_ok;

    // Read data owns the bus from the cycle after RD_CMD until it is captured,
    // so any write beat in that window would collide and is dropped instead.
    assign w_rd_cap = r_rd_pipe[CAS_LATENCY-1];
    assign w_rd_due = |r_rd_pipe[CAS_LATENCY-1:0];
    assign w_wr_ok  = WR_EN & ~RD_CMD & ~w_rd_due;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_rd_pipe  <= '0;
            r_dqout    <= '0;
            r_dataout  <= '0;
            r_dqm      <= {MSIZE{1'b1}};
            r_dq_oe    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_wr_drop  <= 1'b0;
        end else begin
            r_rd_pipe  <= {r_rd_pipe[CAS_LATENCY-1:0], RD_CMD};
            r_rd_valid <= w_rd_cap;
            r_wr_drop  <= WR_EN & ~w_wr_ok;
            if (w_rd_cap) begin
                r_dataout <= DQIN;
            end
            if (w_wr_ok) begin
                r_dqout <= DATAIN;
                r_dqm   <= DM;
                r_dq_oe <= 1'b1;
            end else if (RD_CMD) begin
                r_dqm   <= RD_DM;
                r_dq_oe <= 1'b0;
            end else begin
                r_dqm   <= {MSIZE{1'b1}};
                r_dq_oe <= 1'b0;
            end
        end
    end

    assign DQOUT    = r_dqout;
    assign DQ_OE    = r_dq_oe;
    assign DQM      = r_dqm;
    assign DATAOUT  = r_dataout;
    assign RD_VALID = r_rd_valid;
    assign RD_BUSY  = |r_rd_pipe;
    assign WR_DROP  = r_wr_drop;

endmodule

// File: tb/tb_sdr_data_path_cl.sv
// Directed vector bench for sdr_data_path_cl: DSIZE=16/CL=3 and DSIZE=32/CL=2
// instances, cycle tables plus hand-written reset sequences.
module tb_sdr_data_path_cl;

    typedef struct {
        logic        wr;
        logic [31:0] din;
        logic [3:0]  dm;
        logic        rd;
        logic [3:0]  rdm;
        logic [31:0] dqin;
        logic [31:0] e_dqout;
        logic        e_oe;
        logic [3:0]  e_dqm;
        logic [31:0] e_dout;
        logic        e_v;
        logic        e_busy;
        logic        e_drop;
    } vec_t;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    // DSIZE=16, CL=3 instance
    logic        a_wr_en, a_rd_cmd, a_dq_oe, a_rd_valid, a_rd_busy, a_wr_drop;
    logic [15:0] a_datain, a_dqin, a_dqout, a_dataout;
    logic [1:0]  a_dm, a_rd_dm, a_dqm;

    // DSIZE=32, CL=2 instance
    logic        b_wr_en, b_rd_cmd, b_dq_oe, b_rd_valid, b_rd_busy, b_wr_drop;
    logic [31:0] b_datain, b_dqin, b_dqout, b_dataout;
    logic [3:0]  b_dm, b_rd_dm, b_dqm;

    sdr_data_path_cl #(.DSIZE(16), .CAS_LATENCY(3)) u_a (
        .CLK(CLK), .RESET(RESET), .WR_EN(a_wr_en), .DATAIN(a_datain), .DM(a_dm),
        .RD_CMD(a_rd_cmd), .RD_DM(a_rd_dm), .DQIN(a_dqin), .DQOUT(a_dqout),
        .DQ_OE(a_dq_oe), .DQM(a_dqm), .DATAOUT(a_dataout), .RD_VALID(a_rd_valid),
        .RD_BUSY(a_rd_busy), .WR_DROP(a_wr_drop)
    );

    sdr_data_path_cl #(.DSIZE(32), .CAS_LATENCY(2)) u_b (
        .CLK(CLK), .RESET(RESET), .WR_EN(b_wr_en), .DATAIN(b_datain), .DM(b_dm),
        .RD_CMD(b_rd_cmd), .RD_DM(b_rd_dm), .DQIN(b_dqin), .DQOUT(b_dqout),
        .DQ_OE(b_dq_oe), .DQM(b_dqm), .DATAOUT(b_dataout), .RD_VALID(b_rd_valid),
        .RD_BUSY(b_rd_busy), .WR_DROP(b_wr_drop)
    );

    int n_checks = 0;
    int n_fail   = 0;

    vec_t ta[23];
    vec_t tb[8];

    function automatic vec_t mk(input logic wr, input logic [31:0] din, input logic [3:0] dm,
                                input logic rd, input logic [3:0] rdm, input logic [31:0] dqin,
                                input logic [31:0] e_dqout, input logic e_oe, input logic [3:0] e_dqm,
                                input logic [31:0] e_dout, input logic e_v, input logic e_busy,
                                input logic e_drop);
        vec_t v;
        v.wr = wr; v.din = din; v.dm = dm; v.rd = rd; v.rdm = rdm; v.dqin = dqin;
        v.e_dqout = e_dqout; v.e_oe = e_oe; v.e_dqm = e_dqm; v.e_dout = e_dout;
        v.e_v = e_v; v.e_busy = e_busy; v.e_drop = e_drop;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_a(input string tag, input vec_t v);
        chk({tag, " DQOUT"},    32'(a_dqout),    v.e_dqout);
        chk({tag, " DQ_OE"},    32'(a_dq_oe),    32'(v.e_oe));
        chk({tag, " DQM"},      32'(a_dqm),      32'(v.e_dqm));
        chk({tag, " DATAOUT"},  32'(a_dataout),  v.e_dout);
        chk({tag, " RD_VALID"}, 32'(a_rd_valid), 32'(v.e_v));
        chk({tag, " RD_BUSY"},  32'(a_rd_busy),  32'(v.e_busy));
        chk({tag, " WR_DROP"},  32'(a_wr_drop),  32'(v.e_drop));
    endtask

    task automatic chk_b(input string tag, input vec_t v);
        chk({tag, " DQOUT"},    b_dqout,         v.e_dqout);
        chk({tag, " DQ_OE"},    32'(b_dq_oe),    32'(v.e_oe));
        chk({tag, " DQM"},      32'(b_dqm),      32'(v.e_dqm));
        chk({tag, " DATAOUT"},  b_dataout,       v.e_dout);
        chk({tag, " RD_VALID"}, 32'(b_rd_valid), 32'(v.e_v));
        chk({tag, " RD_BUSY"},  32'(b_rd_busy),  32'(v.e_busy));
        chk({tag, " WR_DROP"},  32'(b_wr_drop),  32'(v.e_drop));
    endtask

    task automatic drive_a(input vec_t v);
        a_wr_en = v.wr; a_datain = v.din[15:0]; a_dm = v.dm[1:0];
        a_rd_cmd = v.rd; a_rd_dm = v.rdm[1:0]; a_dqin = v.dqin[15:0];
    endtask

    task automatic drive_b(input vec_t v);
        b_wr_en = v.wr; b_datain = v.din; b_dm = v.dm;
        b_rd_cmd = v.rd; b_rd_dm = v.rdm; b_dqin = v.dqin;
    endtask

    initial begin
        vec_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        //            wr din        dm    rd rdm   dqin         dqout      oe dqm    dout       v  busy drop
        ta[0]  = mk(1, 32'h1111, 4'h0, 0, 4'h0, 32'hA000, 32'h1111, 1, 4'h0, 32'h0000, 0, 0, 0);
        ta[1]  = mk(1, 32'h2222, 4'h1, 0, 4'h0, 32'hA001, 32'h2222, 1, 4'h1, 32'h0000, 0, 0, 0);
        ta[2]  = mk(1, 32'h3333, 4'h2, 0, 4'h0, 32'hA002, 32'h3333, 1, 4'h2, 32'h0000, 0, 0, 0);
        ta[3]  = mk(1, 32'h4444, 4'h0, 0, 4'h0, 32'hA003, 32'h4444, 1, 4'h0, 32'h0000, 0, 0, 0);
        ta[4]  = mk(0, 32'h0000, 4'h0, 0, 4'h0, 32'hA004, 32'h4444, 0, 4'h3, 32'h0000, 0, 0, 0);
        ta[5]  = mk(0, 32'h0000, 4'h0, 1, 4'h0, 32'hA005, 32'h4444, 0, 4'h0, 32'h0000, 0, 1, 0);
        ta[6]  = mk(0, 32'h0000, 4'h0, 1, 4'h1, 32'hA006, 32'h4444, 0, 4'h1, 32'h0000, 0, 1, 0);
        ta[7]  = mk(0, 32'h0000, 4'h0, 1, 4'h2, 32'hA007, 32'h4444, 0, 4'h2, 32'h0000, 0, 1, 0);
        ta[8]  = mk(0, 32'h0000, 4'h0, 1, 4'h0, 32'hA008, 32'h4444, 0, 4'h0, 32'hA008, 1, 1, 0);
        ta[9]  = mk(0, 32'h0000, 4'h0, 0, 4'h0, 32'hA009, 32'h4444, 0, 4'h3, 32'hA009, 1, 1, 0);
        ta[10] = mk(0, 32'h0000, 4'h0, 0, 4'h0, 32'hA00A, 32'h4444, 0, 4'h3, 32'hA00A, 1, 1, 0);
        ta[11] = mk(0, 32'h0000, 4'h0, 0, 4'h0, 32'hA00B, 32'h4444, 0, 4'h3, 32'hA00B, 1, 1, 0);
        ta[12] = mk(0, 32'h0000, 4'h0, 0, 4'h0, 32'hA00C, 32'h4444, 0, 4'h3, 32'hA00B, 0, 0, 0);
        ta[13] = mk(0, 32'h0000, 4'h0, 1, 4'h2, 32'hA00D, 32'h4444, 0, 4'h2, 32'hA00B, 0, 1, 0);
        ta[14] = mk(1, 32'h5555, 4'h0, 0, 4'h0, 32'hA00E, 32'h4444, 0, 4'h3, 32'hA00B, 0, 1, 1);
        ta[15] = mk(1, 32'h6666, 4'h0, 0, 4'h0, 32'hA00F, 32'h4444, 0, 4'h3, 32'hA00B, 0, 1, 1);
        ta[16] = mk(1, 32'h7777, 4'h0, 0, 4'h0, 32'hBEEF, 32'h4444, 0, 4'h3, 32'hBEEF, 1, 1, 1);
        ta[17] = mk(1, 32'h8888, 4'h1, 0, 4'h0, 32'hA011, 32'h8888, 1, 4'h1, 32'hBEEF, 0, 0, 0);
        ta[18] = mk(1, 32'h9999, 4'h0, 1, 4'h1, 32'hA012, 32'h8888, 0, 4'h1, 32'hBEEF, 0, 1, 1);
        ta[19] = mk(0, 32'h0000, 4'h0, 0, 4'h0, 32'hA013, 32'h8888, 0, 4'h3, 32'hBEEF, 0, 1, 0);
        ta[20] = mk(0, 32'h0000, 4'h0, 0, 4'h0, 32'hA014, 32'h8888, 0, 4'h3, 32'hBEEF, 0, 1, 0);
        ta[21] = mk(0, 32'h0000, 4'h0, 0, 4'h0, 32'hCAFE, 32'h8888, 0, 4'h3, 32'hCAFE, 1, 1, 0);
        ta[22] = mk(0, 32'h0000, 4'h0, 0, 4'h0, 32'hA016, 32'h8888, 0, 4'h3, 32'hCAFE, 0, 0, 0);

        tb[0] = mk(1, 32'h11112222, 4'h0, 0, 4'h0, 32'hFFFF0000, 32'h11112222, 1, 4'h0, 32'h00000000, 0, 0, 0);
        tb[1] = mk(1, 32'h33334444, 4'hA, 0, 4'h0, 32'hFFFF0001, 32'h33334444, 1, 4'hA, 32'h00000000, 0, 0, 0);
        tb[2] = mk(0, 32'h00000000, 4'h0, 0, 4'h0, 32'hFFFF0002, 32'h33334444, 0, 4'hF, 32'h00000000, 0, 0, 0);
        tb[3] = mk(0, 32'h00000000, 4'h0, 1, 4'h3, 32'hFFFF0003, 32'h33334444, 0, 4'h3, 32'h00000000, 0, 1, 0);
        tb[4] = mk(0, 32'h00000000, 4'h0, 1, 4'hC, 32'hFFFF0004, 32'h33334444, 0, 4'hC, 32'h00000000, 0, 1, 0);
        tb[5] = mk(0, 32'h00000000, 4'h0, 0, 4'h0, 32'h5A5A5A5A, 32'h33334444, 0, 4'hF, 32'h5A5A5A5A, 1, 1, 0);
        tb[6] = mk(1, 32'hAAAA0000, 4'h0, 0, 4'h0, 32'h6B6B6B6B, 32'h33334444, 0, 4'hF, 32'h6B6B6B6B, 1, 1, 1);
        tb[7] = mk(1, 32'hBBBB0000, 4'h1, 0, 4'h0, 32'hFFFF0007, 32'hBBBB0000, 1, 4'h1, 32'h6B6B6B6B, 0, 0, 0);

        drive_a(idle);
        drive_b(idle);
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk_a("A reset", mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 4'h3, 32'h0, 0, 0, 0));
        chk_b("B reset", mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 4'hF, 32'h0, 0, 0, 0));
        RESET = 1'b0;

        for (int r = 0; r < 23; r++) begin
            drive_a(ta[r]);
            @(posedge CLK);
            #1;
            $display("A row %0d wr=%b rd=%b dqout=%h oe=%b dqm=%b dout=%h v=%b busy=%b drop=%b",
                     r, ta[r].wr, ta[r].rd, a_dqout, a_dq_oe, a_dqm, a_dataout, a_rd_valid,
                     a_rd_busy, a_wr_drop);
            chk_a($sformatf("A row %0d", r), ta[r]);
        end
        drive_a(idle);

        for (int r = 0; r < 8; r++) begin
            drive_b(tb[r]);
            @(posedge CLK);
            #1;
            $display("B row %0d wr=%b rd=%b dqout=%h oe=%b dqm=%b dout=%h v=%b busy=%b drop=%b",
                     r, tb[r].wr, tb[r].rd, b_dqout, b_dq_oe, b_dqm, b_dataout, b_rd_valid,
                     b_rd_busy, b_wr_drop);
            chk_b($sformatf("B row %0d", r), tb[r]);
        end
        drive_b(idle);

        // Reset with two reads in flight: nothing from them may surface afterwards.
        a_rd_cmd = 1'b1; a_rd_dm = 2'b01;
        repeat (2) @(posedge CLK);
        #1;
        chk("A pre-reset RD_BUSY", 32'(a_rd_busy), 32'd1);
        chk("A pre-reset DQM", 32'(a_dqm), 32'd1);
        #3 RESET = 1'b1;
        #1;
        $display("A async reset mid-read dqm=%b busy=%b v=%b dout=%h", a_dqm, a_rd_busy, a_rd_valid, a_dataout);
        chk("A async reset DQM", 32'(a_dqm), 32'h3);
        chk("A async reset RD_BUSY", 32'(a_rd_busy), 32'd0);
        chk("A async reset RD_VALID", 32'(a_rd_valid), 32'd0);
        chk("A async reset DATAOUT", 32'(a_dataout), 32'h0);
        a_rd_cmd = 1'b0;
        @(posedge CLK);
        #1 RESET = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge CLK);
            #1;
            $display("A post-reset cycle %0d v=%b busy=%b", c, a_rd_valid, a_rd_busy);
            chk($sformatf("A post-reset %0d RD_VALID", c), 32'(a_rd_valid), 32'd0);
            chk($sformatf("A post-reset %0d RD_BUSY", c), 32'(a_rd_busy), 32'd0);
        end

        // Reset while driving a write beat onto the bus.
        a_wr_en = 1'b1; a_datain = 16'h5AA5; a_dm = 2'b10;
        @(posedge CLK);
        #1;
        a_wr_en = 1'b0;
        chk("A pre-reset DQ_OE", 32'(a_dq_oe), 32'd1);
        chk("A pre-reset DQOUT", 32'(a_dqout), 32'h5AA5);
        #3 RESET = 1'b1;
        #1;
        $display("A async reset mid-write oe=%b dqout=%h dqm=%b", a_dq_oe, a_dqout, a_dqm);
        chk("A async reset DQ_OE", 32'(a_dq_oe), 32'd0);
        chk("A async reset DQOUT", 32'(a_dqout), 32'h0);
        chk("A async reset DQM after write", 32'(a_dqm), 32'h3);
        @(posedge CLK);
        #1 RESET = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
